data_mem_mmio: RTL and testbench
================================

// Module: data_mem_mmio
// PURPOSE
//  Data-memory stage that sits directly downstream of the single-cycle MIPS core: it consumes the core's
//  mem_write / datamem_add / write_data and returns datamem_readdata in the same cycle (combinational read).
//  Word RAM below MMIO_BASE; above it, a small MMIO page: byte TX FIFO with valid/ready drain, LED register,
//  free-running cycle counter. Lets programs emit debug bytes and time themselves without extra core logic.
// PARAMETERS
//  DEPTH_WORDS  64            RAM size in 32-bit words; power of 2
//  FIFO_DEPTH   8             TX FIFO entries (bytes); power of 2, >=2
//  MMIO_BASE    32'hFFFF_0000 Start of MMIO page; addr >= MMIO_BASE decodes as MMIO
// PORTS
//  clk               in   1   Clock, all state updates on rising edge
//  rst               in   1   Synchronous, active-high reset
//  mem_write         in   1   Store strobe from core (one store per asserted cycle)
//  datamem_add       in   32  Byte address from core ALU
//  write_data        in   32  Store data from core
//  datamem_readdata  out  32  Load data, combinational from datamem_add
//  tx_data           out  8   FIFO head byte
//  tx_valid          out  1   FIFO non-empty
//  tx_ready          in   1   Consumer accepts head when tx_valid && tx_ready
//  led               out  8   LED register
//  addr_err          out  1   One-cycle pulse, registered: bad store seen in previous cycle
// BEHAVIOUR
//  Reset: led=0, cycle counter=0, FIFO empty (tx_valid=0, tx_data=0), overflow=0, addr_err=0. RAM NOT reset.
//  RAM (addr < MMIO_BASE): index = addr[log2(DEPTH_WORDS)+1:2]; upper bits ignored (aliases/wraps).
//   Store writes full word at posedge. Load combinational; same-cycle load+store to one word returns OLD data.
//   Misaligned (addr[1:0]!=0): store suppressed, addr_err=1 next cycle; load returns aligned word.
//  MMIO map (offset from MMIO_BASE, word aligned; addr[1:0] ignored in MMIO):
//   +0x0 TXDATA  W: push write_data[7:0]. R: 0.
//   +0x4 TXSTAT  R: {24'b0, count[3:0], ovf, empty, full, 1'b0} i.e. bit1 full, bit2 empty, bit3 ovf,
//                bits[7:4] occupancy (saturating at 15). W: write_data[3]=1 clears ovf; other bits ignored.
//   +0x8 LED     R/W: led <= write_data[7:0]; read {24'b0, led}.
//   +0xC CYCLES  R: 32-bit counter, +1 every cycle after reset, wraps 0xFFFF_FFFF->0. W: ignored, no error.
//   Other offsets: read 0; store ignored, addr_err pulses.
//  FIFO: circular buffer, rd/wr pointers with extra wrap bit. tx_valid = !empty; tx_data = mem[rd_ptr].
//   Pop on tx_valid && tx_ready. Push on store to TXDATA.
//   Push when full and no pop: byte dropped, ovf <= 1 (sticky until cleared or rst).
//   Push when full with pop same cycle: push accepted, occupancy unchanged, no ovf.
//   Push when empty: no fall-through; tx_valid rises the following cycle.
//   ovf clear and new overflow in same cycle: set wins.
//  Latency: stores/pushes visible on reads the cycle after the edge; loads zero-latency.
//  Reset mid-operation: FIFO contents discarded, pending byte on tx_data dropped, tx_valid low next cycle.
// TESTING
//  1. rst 1 cycle; store 0xDEADBEEF @0x10, load @0x10 next cycle -> 0xDEADBEEF; load @0x110 (DEPTH 64) -> same.
//  2. Store 0x1234 @0x13 -> RAM @0x10 unchanged, addr_err=1 exactly one cycle later, then 0.
//  3. tx_ready=0; push 0x41..0x48 (8) -> TXSTAT full=1 count=8; 9th push 0x49 -> ovf=1, bytes out 0x41..0x48 in order.
//  4. FIFO full, tx_ready=1 and push 0x50 same cycle -> no ovf, count stays 8, 0x50 emerges last.
//  5. Store 0xA5 to LED -> led=0xA5 next cycle, readback 0xA5; rst -> led=0, CYCLES read 0 in first post-reset cycle, 5 after 5 cycles.
//  6. Push 3 bytes, assert rst with tx_ready=0 -> tx_valid=0 after reset, TXSTAT=0x04 (empty), ovf=0.

Source files
------------

// File: rtl/data_mem_mmio.sv
// -----------------------------------------------------------------------------
// data_mem_mmio
//   Data-memory stage for a single-cycle MIPS core. Addresses below MMIO_BASE
//   hit a word RAM. Addresses at or above MMIO_BASE hit a small MMIO page:
//     +0x0 TXDATA  store pushes a byte into the TX FIFO, reads 0
//     +0x4 TXSTAT  {count[3:0], ovf, empty, full, 0}; writing bit3=1 clears ovf
//     +0x8 LED     8-bit LED register, read/write
//     +0xC CYCLES  free-running cycle counter, read-only (stores ignored)
//   Loads are combinational. Stores take effect on the rising edge.
//
// Ports
//   clk              clock, all state updates on the rising edge
//   rst              synchronous active-high reset
//   mem_write        store strobe from the core
//   datamem_add      byte address from the core ALU
//   write_data       store data
//   datamem_readdata load data, combinational from datamem_add
//   tx_data          FIFO head byte (0 while the FIFO is empty)
//   tx_valid         FIFO non-empty
//   tx_ready         consumer accepts the head when tx_valid && tx_ready
//   led              LED register
//   addr_err         one-cycle pulse: a bad store was seen on the previous edge
// -----------------------------------------------------------------------------
module data_mem_mmio #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic [31:0] datamem_add,
  input  logic [31:0] write_data,
  output logic [31:0] datamem_readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  led,
  output logic        addr_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          is_mmio;
  logic [31:0]   mmio_off;
  logic [29:0]   mmio_word;
  logic          sel_txdata;
  logic          sel_txstat;
  logic          sel_led;
  logic          sel_cycles;
  logic          misaligned;
  logic [AW-1:0] ram_idx;

  assign is_mmio    = (datamem_add >= MMIO_BASE);
  assign mmio_off   = datamem_add - MMIO_BASE;
  // Byte lane bits are don't-care inside the MMIO page.
  assign mmio_word  = mmio_off[31:2];
  assign sel_txdata = is_mmio && (mmio_word == 30'd0);
  assign sel_txstat = is_mmio && (mmio_word == 30'd1);
  assign sel_led    = is_mmio && (mmio_word == 30'd2);
  assign sel_cycles = is_mmio && (mmio_word == 30'd3);
  assign misaligned = (datamem_add[1:0] != 2'b00);
  // Upper address bits are ignored, so RAM aliases across the space below MMIO.
  assign ram_idx    = datamem_add[AW+1:2];

  logic unused_ok;
  assign unused_ok = &{1'b0, mmio_off[1:0]};

  // ---------------------------------------------------------------------------
  // Word RAM (not reset). Read is combinational, so a same-cycle load of the
  // word being stored still returns the old contents.
  // ---------------------------------------------------------------------------
  logic [31:0] ram [DEPTH_WORDS];
  logic        ram_we;

  assign ram_we = mem_write && !is_mmio && !misaligned;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= write_data;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO: pointers carry an extra wrap bit so full and empty are distinct.
  // ---------------------------------------------------------------------------
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr_reg;
  logic [PW:0] rd_ptr_reg;
  logic [PW:0] count_w;
  logic        full;
  logic        empty;
  logic        push_req;
  logic        push_ok;
  logic        pop;
  logic        ovf_reg;
  logic        ovf_set;
  logic        ovf_clr;
  logic [3:0]  stat_count;

  assign count_w  = wr_ptr_reg - rd_ptr_reg;
  assign full     = (count_w == (PW+1)'(FIFO_DEPTH));
  assign empty    = (count_w == '0);
  assign pop      = !empty && tx_ready;
  assign push_req = mem_write && sel_txdata;
  // A full FIFO still accepts a push when the head leaves in the same cycle:
  // the new byte lands in the slot being vacated.
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = mem_write && sel_txstat && write_data[3];

  always_comb begin
    if (32'(count_w) > 32'd15) begin
      stat_count = 4'hF;
    end else begin
      stat_count = 4'(count_w);
    end
  end

  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr_reg[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg[PW-1:0]] <= write_data[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Control state: FIFO pointers, ovf, LED, cycle counter, error pulse
  // ---------------------------------------------------------------------------
  logic [7:0]  led_reg;
  logic [31:0] cycles_reg;
  logic        addr_err_reg;
  logic        bad_store;

  // Misaligned RAM stores and stores to unmapped MMIO offsets are errors;
  // a store to CYCLES is silently ignored.
  assign bad_store = mem_write &&
                     (is_mmio ? !(sel_txdata || sel_txstat || sel_led || sel_cycles)
                              : misaligned);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      ovf_reg      <= 1'b0;
      led_reg      <= 8'h00;
      cycles_reg   <= 32'h0;
      addr_err_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      // New overflow beats a simultaneous clear.
      if (ovf_set) begin
        ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
        ovf_reg <= 1'b0;
      end
      if (mem_write && sel_led) begin
        led_reg <= write_data[7:0];
      end
      cycles_reg   <= cycles_reg + 32'd1;
      addr_err_reg <= bad_store;
    end
  end

  assign led      = led_reg;
  assign addr_err = addr_err_reg;

  // ---------------------------------------------------------------------------
  // Load mux
  // ---------------------------------------------------------------------------
  always_comb begin
    datamem_readdata = 32'h0;
    if (!is_mmio) begin
      datamem_readdata = ram[ram_idx];
    end else if (sel_txstat) begin
      datamem_readdata = {24'h0, stat_count, ovf_reg, empty, full, 1'b0};
    end else if (sel_led) begin
      datamem_readdata = {24'h0, led_reg};
    end else if (sel_cycles) begin
      datamem_readdata = cycles_reg;
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
module tb_data_mem_mmio;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int          NW   = 64;
  localparam int          NF   = 8;

  logic        clk;
  logic        rst;
  logic        mem_write;
  logic [31:0] datamem_add;
  logic [31:0] write_data;
  logic [31:0] datamem_readdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  led;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  data_mem_mmio #(
    .DEPTH_WORDS(NW),
    .FIFO_DEPTH (NF),
    .MMIO_BASE  (BASE)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_write       (mem_write),
    .datamem_add     (datamem_add),
    .write_data      (write_data),
    .datamem_readdata(datamem_readdata),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .led             (led),
    .addr_err        (addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [31:0] m_ram [NW];
  logic [7:0]  m_fifo [$];
  bit          m_ovf;
  logic [7:0]  m_led;
  logic [31:0] m_cyc;
  bit          m_err;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int unsigned widx;
    int unsigned cnt;
    if (a >= BASE) begin
      widx = (a - BASE) / 4;
      cnt  = m_fifo.size();
      if (cnt > 15) cnt = 15;
      case (widx)
        1: return cnt * 16 + (m_ovf ? 8 : 0) + (m_fifo.size() == 0 ? 4 : 0)
                  + (m_fifo.size() == NF ? 2 : 0);
        2: return {24'h0, m_led};
        3: return m_cyc;
        default: return 32'h0;
      endcase
    end
    return m_ram[(a / 4) % NW];
  endfunction

  function automatic logic [7:0] m_head();
    if (m_fifo.size() == 0) return 8'h00;
    return m_fifo[0];
  endfunction

  // Applies the effect of one rising edge to the model using current inputs.
  task automatic model_edge();
    bit          is_m;
    int unsigned widx;
    bit          pop;
    bit          was_full;
    bit          set;
    if (rst) begin
      m_fifo.delete();
      m_ovf = 0;
      m_led = 8'h00;
      m_cyc = 32'h0;
      m_err = 0;
      return;
    end
    is_m     = (datamem_add >= BASE);
    widx     = (datamem_add - BASE) / 4;
    pop      = (m_fifo.size() > 0) && tx_ready;
    was_full = (m_fifo.size() == NF);
    set      = 0;
    if (pop) void'(m_fifo.pop_front());
    if (mem_write && is_m && widx == 0) begin
      if (!was_full || pop) m_fifo.push_back(write_data[7:0]);
      else set = 1;
    end
    if (set) m_ovf = 1;
    else if (mem_write && is_m && widx == 1 && write_data[3]) m_ovf = 0;
    if (mem_write && is_m && widx == 2) m_led = write_data[7:0];
    if (mem_write && !is_m && (datamem_add % 4) == 0)
      m_ram[(datamem_add / 4) % NW] = write_data;
    m_err = mem_write && (is_m ? (widx > 3) : ((datamem_add % 4) != 0));
    m_cyc = m_cyc + 1;
  endtask

  task automatic set_in(input bit w, input logic [31:0] a, input logic [31:0] d);
    mem_write   = w;
    datamem_add = a;
    write_data  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    mem_write = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    set_in(1'b1, a, d);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_write = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    set_in(1'b0, a, 32'h0);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", led); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
    rd(BASE + 32'h4);
    checks++; if (datamem_readdata !== 32'h4) begin errors++; $display("FAIL reset_txstat: got %h expected 00000004", datamem_readdata); end
    rd(BASE + 32'hC);
    checks++; if (datamem_readdata !== 32'h0) begin errors++; $display("FAIL reset_cycles: got %h expected 0", datamem_readdata); end
    $display("test_reset done");
  endtask

  task automatic test_ram();
    // Fill every word so the model knows all RAM contents.
    for (int i = 0; i < NW; i++) store(i * 4, $urandom);
    store(32'h10, 32'hDEAD_BEEF);
    rd(32'h10);
    checks++; if (datamem_readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_load: got %h expected deadbeef", datamem_readdata); end
    rd(32'h110);
    checks++; if (datamem_readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_alias: got %h expected deadbeef", datamem_readdata); end
    // Same-cycle load and store to one word returns the old data.
    set_in(1'b1, 32'h10, 32'h0000_0055);
    #1;
    checks++; if (datamem_readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_old_data: got %h expected deadbeef", datamem_readdata); end
    tick();
    rd(32'h10);
    checks++; if (datamem_readdata !== 32'h0000_0055) begin errors++; $display("FAIL ram_new_data: got %h expected 00000055", datamem_readdata); end
    store(32'h10, 32'hDEAD_BEEF);
    $display("test_ram done");
  endtask

  task automatic test_misaligned();
    store(32'h13, 32'h1234);
    rd(32'h10);
    checks++; if (datamem_readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL misaligned_suppressed: got %h expected deadbeef", datamem_readdata); end
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL misaligned_err_pulse: got %b expected 1", addr_err); end
    tick();
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL misaligned_err_clear: got %b expected 0", addr_err); end
    rd(32'h11);
    checks++; if (datamem_readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL misaligned_load: got %h expected deadbeef", datamem_readdata); end
    store(BASE + 32'h10, 32'h1);
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL mmio_bad_offset_err: got %b expected 1", addr_err); end
    rd(BASE + 32'h10);
    checks++; if (datamem_readdata !== 32'h0) begin errors++; $display("FAIL mmio_bad_offset_read: got %h expected 0", datamem_readdata); end
    store(BASE + 32'hC, 32'h1234_5678);
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL cycles_write_no_err: got %b expected 0", addr_err); end
    $display("test_misaligned done");
  endtask

  task automatic test_fifo_overflow();
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) store(BASE, 32'h41 + i);
    rd(BASE + 32'h4);
    checks++; if (datamem_readdata !== 32'h82) begin errors++; $display("FAIL fifo_full_stat: got %h expected 00000082", datamem_readdata); end
    store(BASE + 32'h2, 32'h49);  // byte lanes ignored in MMIO
    rd(BASE + 32'h4);
    checks++; if (datamem_readdata !== 32'h8A) begin errors++; $display("FAIL fifo_ovf_stat: got %h expected 0000008a", datamem_readdata); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(32'h41 + i)) begin
        errors++; $display("FAIL fifo_drain_%0d: got v=%b d=%h expected v=1 d=%h", i, tx_valid, tx_data, 8'(32'h41 + i));
      end
      tick();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL fifo_drained_empty: got %b expected 0", tx_valid); end
    $display("test_fifo_overflow done");
  endtask

  task automatic test_full_push_pop();
    store(BASE + 32'h4, 32'h8);   // clear ovf
    rd(BASE + 32'h4);
    checks++; if (datamem_readdata !== 32'h4) begin errors++; $display("FAIL ovf_clear: got %h expected 00000004", datamem_readdata); end
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) store(BASE, 32'h60 + i);
    tx_ready = 1'b1;
    store(BASE, 32'h50);
    tx_ready = 1'b0;
    rd(BASE + 32'h4);
    checks++; if (datamem_readdata !== 32'h82) begin errors++; $display("FAIL full_push_pop_stat: got %h expected 00000082", datamem_readdata); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_data !== ((i == 7) ? 8'h50 : 8'(32'h61 + i))) begin
        errors++; $display("FAIL full_push_pop_order_%0d: got %h expected %h", i, tx_data, (i == 7) ? 8'h50 : 8'(32'h61 + i));
      end
      tick();
    end
    $display("test_full_push_pop done");
  endtask

  task automatic test_led_cycles();
    store(BASE + 32'h8, 32'hFFFF_FFA5);
    checks++; if (led !== 8'hA5) begin errors++; $display("FAIL led_out: got %h expected a5", led); end
    rd(BASE + 32'h8);
    checks++; if (datamem_readdata !== 32'hA5) begin errors++; $display("FAIL led_read: got %h expected 000000a5", datamem_readdata); end
    do_reset();
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL led_reset: got %h expected 00", led); end
    rd(BASE + 32'hC);
    checks++; if (datamem_readdata !== 32'd0) begin errors++; $display("FAIL cycles_first: got %0d expected 0", datamem_readdata); end
    for (int i = 0; i < 5; i++) tick();
    rd(BASE + 32'hC);
    checks++; if (datamem_readdata !== 32'd5) begin errors++; $display("FAIL cycles_five: got %0d expected 5", datamem_readdata); end
    $display("test_led_cycles done");
  endtask

  task automatic test_reset_midop();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) store(BASE, $urandom);  // includes one overflow
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL midop_valid_before: got %b expected 1", tx_valid); end
    do_reset();
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL midop_tx_after: got v=%b d=%h expected v=0 d=00", tx_valid, tx_data); end
    rd(BASE + 32'h4);
    checks++; if (datamem_readdata !== 32'h4) begin errors++; $display("FAIL midop_txstat: got %h expected 00000004", datamem_readdata); end
    $display("test_reset_midop done");
  endtask

  task automatic test_random();
    logic [31:0] a;
    bit          w;
    for (int n = 0; n < 400; n++) begin
      w = 1'b0;
      case ($urandom_range(0, 9))
        0, 1, 2: begin a = $urandom & 32'h0000_0FFF; w = $urandom_range(0, 1) == 1; end
        3:       begin a = BASE + $urandom_range(0, 3); w = $urandom_range(0, 3) != 0; end
        4:       begin a = BASE + 32'h4 + $urandom_range(0, 3); w = $urandom_range(0, 1) == 1; end
        5:       begin a = BASE + 32'h8; w = $urandom_range(0, 1) == 1; end
        6:       begin a = BASE + 32'hC; w = $urandom_range(0, 1) == 1; end
        7:       begin a = BASE + 32'h10 + $urandom_range(0, 63); w = $urandom_range(0, 1) == 1; end
        default: begin a = BASE + $urandom_range(0, 15); end
      endcase
      set_in(w, a, $urandom);
      tx_ready = ($urandom_range(0, 2) == 0);
      #1;
      checks++; if (datamem_readdata !== m_read(a)) begin errors++; $display("FAIL rand_read_%0d: addr %h got %h expected %h", n, a, datamem_readdata, m_read(a)); end
      checks++; if (tx_valid !== (m_fifo.size() != 0)) begin errors++; $display("FAIL rand_tx_valid_%0d: got %b expected %b", n, tx_valid, m_fifo.size() != 0); end
      checks++; if (tx_data !== m_head()) begin errors++; $display("FAIL rand_tx_data_%0d: got %h expected %h", n, tx_data, m_head()); end
      checks++; if (led !== m_led) begin errors++; $display("FAIL rand_led_%0d: got %h expected %h", n, led, m_led); end
      checks++; if (addr_err !== m_err) begin errors++; $display("FAIL rand_addr_err_%0d: got %b expected %b", n, addr_err, m_err); end
      tick();
    end
    $display("test_random done");
  endtask

  initial begin
    rst         = 1'b1;
    mem_write   = 1'b0;
    datamem_add = 32'h0;
    write_data  = 32'h0;
    tx_ready    = 1'b0;
    m_ovf       = 0;
    m_led       = 8'h00;
    m_cyc       = 32'h0;
    m_err       = 0;
    test_reset();
    test_ram();
    test_misaligned();
    test_fifo_overflow();
    test_full_push_pop();
    test_led_cycles();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
